// File: rtl/imem_loader.sv
// imem_loader: program loader for the instruction memory.
//
// Accepts a byte stream (valid/ready), assembles little-endian 32-bit words
// and writes them from word address 0 upward through the instruction
// memory's write port. The core is held halted until the whole image has
// been written. The first byte is a header giving the word count
// (0 means 2^ADDR_W words).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte (XOR of the header and all data
//   bytes) must match before the core is released; a mismatch goes to ERR.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   byte_valid source presents a byte
//   byte_data  byte value
//   byte_ready loader accepts a byte (HDR, DATA, CHK)
//   load_req   in RUN or ERR, starts a new load
//   mem_addr   instruction-memory write word address
//   mem_data   instruction-memory write data
//   mem_wren   write strobe, one cycle per word
//   core_halt  holds the core in every state except RUN
//   done       1 only in RUN
//   error      1 only in ERR
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              core_halt,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAP = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, DATA, WRITE, CHK, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {HDR, DATA, WRITE, RUN, ERR} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   widx_q;
    logic [ADDR_W:0]   widx_inc;
    logic [1:0]        bidx_q;
    logic [23:0]       asm_q;
    logic              byte_ready_q, core_halt_q, done_q, error_q, mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xsum_q;
`endif

    logic [8:0]        hdr_words;
    logic              hdr_ok;
    logic              accept;
    logic              last_word;

    assign accept    = byte_valid & byte_ready_q;
    // Header 0 stands for a full 2^ADDR_W-word image.
    assign hdr_words = (byte_data == 8'd0) ? 9'(CAP) : {1'b0, byte_data};
    assign hdr_ok    = (32'(hdr_words) <= CAP);
    assign widx_inc  = widx_q + (ADDR_W+1)'(1);
    assign last_word = (widx_inc == count_q);

    assign byte_ready = byte_ready_q;
    assign core_halt  = core_halt_q;
    assign done       = done_q;
    assign error      = error_q;
    assign mem_wren   = mem_wren_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR:   if (accept) state_d = hdr_ok ? DATA : ERR;
            DATA:  if (accept && bidx_q == 2'd3) state_d = WRITE;
`ifdef LOADER_CHECKSUM_EN
            WRITE: state_d = last_word ? CHK : DATA;
            CHK:   if (accept) state_d = (byte_data == xsum_q) ? RUN : ERR;
`else
            WRITE: state_d = last_word ? RUN : DATA;
`endif
            RUN:   if (load_req) state_d = HDR;
            ERR:   if (load_req) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HDR;
            byte_ready_q <= 1'b1;
            core_halt_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            count_q      <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            xsum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
`ifdef LOADER_CHECKSUM_EN
            byte_ready_q <= (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
`else
            byte_ready_q <= (state_d == HDR) || (state_d == DATA);
`endif
            core_halt_q  <= (state_d != RUN);
            done_q       <= (state_d == RUN);
            error_q      <= (state_d == ERR);
            mem_wren_q   <= (state_d == WRITE);

            case (state_q)
                HDR: begin
                    if (accept) begin
                        count_q <= hdr_words[ADDR_W:0];
                        widx_q  <= '0;
                        bidx_q  <= '0;
                        asm_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xsum_q  <= xsum_q ^ byte_data;
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        bidx_q <= bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        xsum_q <= xsum_q ^ byte_data;
`endif
                        case (bidx_q)
                            2'd0: asm_q[7:0]   <= byte_data;
                            2'd1: asm_q[15:8]  <= byte_data;
                            2'd2: asm_q[23:16] <= byte_data;
                            default: begin
                                // 4th byte goes straight to the write data.
                                mem_addr_q <= widx_q[ADDR_W-1:0];
                                mem_data_q <= {byte_data, asm_q};
                            end
                        endcase
                    end
                end
                WRITE: widx_q <= widx_inc;
`ifdef LOADER_CHECKSUM_EN
                RUN:   if (load_req) xsum_q <= '0;
                ERR:   if (load_req) xsum_q <= '0;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory the processor core fetches from. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially from word address 0 into the instruction-memory write port. It holds the core halted until a complete image has been written, then releases it. It sits beside the core at the top level and drives the instruction memory's write side, opposite the core's fetch (read) side.

## Interface
- ADDR_W, 6: instruction-memory word-address width; legal range 1..8. Image capacity is 2^ADDR_W words.
- DATA_W, 32: word width; fixed at 32 (4 bytes per word).
- clk  input  1  single clock for all logic; rising-edge.
- reset  input  1  asynchronous, active-low reset.
- byte_valid  input  1  source presents a byte.
- byte_data  input  8  byte value; must be stable while byte_valid=1 and byte_ready=0.
- byte_ready  output  1  loader accepts a byte; transfer occurs on a rising edge where byte_valid=1 and byte_ready=1.
- load_req  input  1  level; in RUN or ERR, starts a new load.
- mem_addr  output  ADDR_W  instruction-memory write word address.
- mem_data  output  32  instruction-memory write data.
- mem_wren  output  1  write strobe, one cycle per word.
- core_halt  output  1  holds the core; 1 in every state except RUN.
- done  output  1  level; 1 only in RUN.
- error  output  1  level; 1 only in ERR.

## Operation
- States: HDR, DATA, WRITE, CHK (macro only), RUN, ERR.
- byte_ready is decoded from state: 1 in HDR, DATA, CHK; 0 in WRITE, RUN, ERR.
- HDR: the accepted byte N is the word count. N=0 encodes 2^ADDR_W words. If N>2^ADDR_W, go to ERR. Otherwise latch the count, clear the word index and byte index, and go to DATA.
- DATA: each accepted byte fills the assembly register at bits [8k+7:8k], where k is the byte index 0..3. Byte 0 is the LSB.
- On the 4th byte, go to WRITE.
- WRITE: lasts one cycle, with mem_wren=1, mem_addr=word index, mem_data=assembled word.
- Leaving WRITE: increment the word index. If the index has reached the count, go to CHK (if enabled) or RUN; otherwise go to DATA.
- The word index never exceeds count-1, so there is no address wrap.
- RUN: core_halt=0, done=1. Stray bytes are not accepted.
- load_req=1 in RUN or ERR moves to HDR on the next edge. core_halt returns to 1 at that edge.
- load_req is ignored in HDR, DATA, WRITE and CHK.
- ERR: error=1 and core_halt=1. Only load_req or reset exits ERR.
- Memory already written is never erased by an error or a reset.

## Timing
- Reset values: state HDR, byte_ready=1, mem_wren=0, mem_addr=0, mem_data=0, core_halt=1, done=0, error=0. All counters and the assembly register are 0.
- mem_wren asserts in the cycle immediately after the edge that accepted the word's 4th byte.
- mem_addr and mem_data are registered and valid in that same cycle.
- Minimum cost is 5 cycles per word: 4 byte cycles plus 1 WRITE cycle.
- byte_valid held high during WRITE stalls the source. The byte is accepted in the first DATA cycle after WRITE, so no byte is lost or duplicated.
- RUN is entered on the edge after the last WRITE cycle (macro off), or after checksum acceptance (macro on).
- Reset asserted mid-load: all outputs take their reset values immediately (asynchronous). A partial word is discarded.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A running XOR covers the header byte and all data bytes.
  - After the last WRITE, the loader enters CHK and accepts one checksum byte.
  - If the checksum byte equals the running XOR, go to RUN; otherwise go to ERR.
  - The running XOR clears on entry to HDR.
- LOADER_CHECKSUM_EN undefined: there is no CHK state and no checksum byte; the loader goes from the last WRITE directly to RUN.

## Test plan
- Two-word load: reset, then bytes 02 78 56 34 12 EF BE AD DE (macro off).
  - Required: mem_wren pulses with addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF.
  - Then core_halt=0, done=1, byte_ready=0.
- Header 00 (ADDR_W=6), then 256 data bytes.
  - Required: exactly 64 writes at addr 0..63, then RUN.
  - A 257th byte is never accepted.
- Oversize header 0x41.
  - Required: ERR on the next edge, error=1, core_halt=1, no mem_wren.
  - load_req then gives HDR with error=0.
- byte_valid held continuously through WRITE cycles; random idle gaps between bytes.
  - Required: identical write sequence to the gap-free run; byte_ready=0 in every WRITE cycle.
- reset pulled low after 2 of 4 words.
  - Required: immediate reset values.
  - A subsequent 1-word load writes addr 0 and reaches RUN.
- Checksum, macro on.
  - Bytes 01 01 02 03 04 then 05: RUN, mem_data=0x04030201.
  - Same bytes then 06: ERR.
  - load_req followed by a valid image: RUN.
